// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names who wins the next contended cycle.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  req_id_e r_ptr;
  req_id_e w_ptr_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= REQ_ALU;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  // Bit 0 is the ALU requester, bit 1 the memory requester.
  always_comb begin
    w_ptr_next = r_ptr;
    o_gnt      = 2'b00;
    case (i_req)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        if (r_ptr == REQ_ALU) begin
          o_gnt      = 2'b01;
          w_ptr_next = REQ_MEM;
        end else begin
          o_gnt      = 2'b10;
          w_ptr_next = REQ_ALU;
        end
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and load writeback and
// tracks pending destination registers for decode hazard detection.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_wb_valid,
  input  logic [AW-1:0]   alu_wb_addr,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            mem_wb_valid,
  input  logic [AW-1:0]   mem_wb_addr,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            mem_wb_ready,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic            hz1,
  output logic            hz2,
  output logic            rg_wrt_en,
  output logic [AW-1:0]   rg_wrt_addr,
  output logic [XLEN-1:0] rg_wrt_data,
  output logic [NREG-1:0] busy_vec
);

  // Handshake: a writeback transfers when valid && ready in the same cycle;
  // ready depends only on the two valids and the arbiter pointer, and a
  // requester holds valid/addr/data stable until it is accepted.
  wb_req_t         w_alu;
  wb_req_t         w_mem;
  wb_req_t         w_sel;
  logic [1:0]      w_gnt;
  logic            w_accept;
  logic [NREG-1:0] w_busy_next;

  logic            r_wrt_en;
  logic [AW-1:0]   r_wrt_addr;
  logic [XLEN-1:0] r_wrt_data;
  logic [NREG-1:0] r_busy;

  assign w_alu = '{valid: alu_wb_valid, addr: alu_wb_addr, data: alu_wb_data};
  assign w_mem = '{valid: mem_wb_valid, addr: mem_wb_addr, data: mem_wb_data};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   ({w_mem.valid, w_alu.valid}),
    .o_gnt   (w_gnt)
  );

  assign alu_wb_ready = w_gnt[0];
  assign mem_wb_ready = w_gnt[1];
  assign w_accept     = |w_gnt;
  assign w_sel        = w_gnt[1] ? w_mem : w_alu;

  // Writes to register 0 complete the handshake but never reach the file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrt_en   <= 1'b0;
      r_wrt_addr <= '0;
      r_wrt_data <= '0;
    end else begin
      r_wrt_en <= w_accept && (w_sel.addr != '0);
      if (w_accept) begin
        r_wrt_addr <= w_sel.addr;
        r_wrt_data <= w_sel.data;
      end
    end
  end

  // Clear on landing first, then set, so a same-edge reservation wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_wrt_en) begin
      w_busy_next[r_wrt_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      w_busy_next[rsv_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign hz1         = r_busy[rd_addr1];
  assign hz2         = r_busy[rd_addr2];
  assign busy_vec    = r_busy;
  assign rg_wrt_en   = r_wrt_en;
  assign rg_wrt_addr = r_wrt_addr;
  assign rg_wrt_data = r_wrt_data;

endmodule
